shift_sequencer: RTL

SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

---
 rtl/shift_sequencer_pkg.sv | 29 ++
 rtl/shift_sequencer_shift.sv | 23 ++
 rtl/shift_sequencer.sv | 121 ++++++++++++
 3 files changed

// File: rtl/shift_sequencer_pkg.sv
// Shared encodings for the shift sequencer and its decoder: shift types, FSM states
// and the effective shift-count rule.
package shift_sequencer_pkg;

  typedef enum logic [1:0] {
    SH_LSL = 2'b00,
    SH_LSR = 2'b01,
    SH_ASR = 2'b10,
    SH_ROR = 2'b11
  } shift_type_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } seq_state_e;

  // Counts beyond 33 (logical) or 32 (arithmetic) cannot change the result, so they are clamped.
  function automatic logic [5:0] eff_count(input shift_type_e typ, input logic [7:0] amount);
    logic [5:0] e;
    case (typ)
      SH_LSL, SH_LSR: e = (amount > 8'd33) ? 6'd33 : amount[5:0];
      SH_ASR:         e = (amount > 8'd32) ? 6'd32 : amount[5:0];
      default:        e = {1'b0, amount[4:0]};
    endcase
    return e;
  endfunction

endpackage

// File: rtl/shift_sequencer_shift.sv
// Combinational barrel shifter for one chunk (0..31 bits) of a register shift.
// Produces only the shifted word; carry is derived by the sequencer.
module shift_sequencer_shift
  import shift_sequencer_pkg::*;
(
  input  logic [31:0]  data_i,
  input  logic [4:0]   amount_i,
  input  shift_type_e  type_i,
  output logic [31:0]  result_o
);

  always_comb begin
    result_o = data_i;
    case (type_i)
      SH_LSL: result_o = data_i << amount_i;
      SH_LSR: result_o = data_i >> amount_i;
      SH_ASR: result_o = $signed(data_i) >>> amount_i;
      SH_ROR: result_o = (data_i >> amount_i) | (data_i << (6'd32 - {1'b0, amount_i}));
      default: result_o = data_i;
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle ARM-style register shifter: applies up to STEP_MAX bits per cycle
// through a single barrel shifter and tracks the shifter carry-out.
//
// state | meaning
// IDLE  | ready for a request
// SHIFT | applying chunks of the latched shift to the working value
// DONE  | result presented until the consumer takes it
module shift_sequencer
  import shift_sequencer_pkg::*;
#(
  parameter int unsigned STEP_MAX = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_data,
  input  logic [7:0]  req_amount,
  input  logic [1:0]  req_type,
  input  logic        req_carry_in,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_carry,
  output logic        busy
);

  localparam logic [5:0] STEP = 6'(STEP_MAX);

  seq_state_e  state_q, state_d;
  logic [31:0] data_q, data_d;
  shift_type_e type_q, type_d;
  logic        carry_q, carry_d;
  logic [5:0]  rem_q, rem_d;

  logic [4:0]  chunk;
  logic [4:0]  lsl_idx;
  logic [4:0]  lsr_idx;
  logic [31:0] shifted;
  shift_type_e req_type_e;
  logic [5:0]  req_eff;

  assign chunk      = (rem_q > STEP) ? STEP[4:0] : rem_q[4:0];
  assign lsl_idx    = 5'(6'd32 - {1'b0, chunk});
  assign lsr_idx    = chunk - 5'd1;
  assign req_type_e = shift_type_e'(req_type);
  assign req_eff    = eff_count(req_type_e, req_amount);

  shift_sequencer_shift u_shift (
    .data_i   (data_q),
    .amount_i (chunk),
    .type_i   (type_q),
    .result_o (shifted)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      type_q  <= SH_LSL;
      carry_q <= 1'b0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      type_q  <= type_d;
      carry_q <= carry_d;
      rem_q   <= rem_d;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    type_d  = type_q;
    carry_d = carry_q;
    rem_d   = rem_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          data_d = req_data;
          type_d = req_type_e;
          rem_d  = '0;
          if (req_amount == 8'd0) begin
            carry_d = req_carry_in;
            state_d = ST_DONE;
          end else if (req_type_e == SH_ROR && req_amount[4:0] == 5'd0) begin
            // Rotation by a non-zero multiple of 32 leaves data intact; carry is bit 31.
            carry_d = req_data[31];
            state_d = ST_DONE;
          end else begin
            carry_d = req_carry_in;
            rem_d   = req_eff;
            state_d = ST_SHIFT;
          end
        end
      end
      ST_SHIFT: begin
        data_d = shifted;
        rem_d  = rem_q - {1'b0, chunk};
        case (type_q)
          SH_LSL:         carry_d = data_q[lsl_idx];
          SH_LSR, SH_ASR: carry_d = data_q[lsr_idx];
          default:        carry_d = shifted[31];
        endcase
        if (rem_d == 6'd0) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign rsp_data  = data_q;
  assign rsp_carry = carry_q;

endmodule
